// File: rtl/exu_bjp_unit.sv
// exu_bjp_unit: pipelined branch/jump resolution unit for the execute stage.
// Accepts one jump/branch per cycle and resolves its direction and target one
// cycle later. Compares the outcome with the fetch prediction and, on a
// mispredict, raises a redirect request that is held until the IFU acks it.
// Optional feature macro: EXU_BJP_BHT_EN. When defined, a table of 2-bit
// saturating counters is trained here and exposes a combinational lookup
// port to fetch. When undefined, o_lkp_taken is tied low and nothing is trained.
module exu_bjp_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [7:0]      i_jump_req,
    input  logic [2:0]      i_cmp_res,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_pred_taken,
    input  logic [XLEN-1:0] i_pred_addr,
    output logic            o_res_valid,
    output logic            o_jump_en,
    output logic [XLEN-1:0] o_jump_addr,
    output logic [XLEN-1:0] o_link_addr,
    output logic            o_misalign,
    output logic            o_flush_req,
    output logic [XLEN-1:0] o_flush_addr,
    input  logic            i_flush_ack,
    input  logic [XLEN-1:0] i_lkp_pc,
    output logic            o_lkp_taken
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic is_jal, is_jalr, is_beq, is_bne, is_blt, is_bge, is_bltu, is_bgeu;
    logic cmp_slt, cmp_sltu, cmp_eq;
    logic has_req;
    logic is_cond;

    assign {is_jal, is_jalr, is_beq, is_bne, is_blt, is_bge, is_bltu, is_bgeu} = i_jump_req;
    assign {cmp_slt, cmp_sltu, cmp_eq} = i_cmp_res;
    assign has_req = |i_jump_req;
    assign is_cond = |i_jump_req[5:0];

    // ------------------------------------------------------------------
    // Resolution datapath (evaluated on the request, registered on accept)
    // ------------------------------------------------------------------
    logic            taken_c;
    logic [XLEN-1:0] base_c;
    logic [XLEN-1:0] sum_c;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] link_c;
    logic            misalign_c;
    logic            mispredict_c;
    logic [XLEN-1:0] redirect_c;
    logic            accept;

    assign taken_c = is_jal | is_jalr
                   | (is_beq  &  cmp_eq)   | (is_bne  & ~cmp_eq)
                   | (is_blt  &  cmp_slt)  | (is_bge  & ~cmp_slt)
                   | (is_bltu &  cmp_sltu) | (is_bgeu & ~cmp_sltu);

    // jalr adds to rs1 and drops bit 0; everything else is pc-relative.
    assign base_c   = is_jalr ? i_rs1 : i_pc;
    assign sum_c    = base_c + i_imm;
    assign target_c = is_jalr ? {sum_c[XLEN-1:1], 1'b0} : sum_c;
    assign link_c   = i_pc + XLEN'(4);

    // A taken target with bit 1 set belongs to the trap path, not to us.
    assign misalign_c = taken_c & target_c[1];

    // An empty request is a plain fall-through and is never checked.
    assign mispredict_c = has_req &
                          ((taken_c != i_pred_taken) |
                           (taken_c & (target_c != i_pred_addr)));

    assign redirect_c = taken_c ? target_c : link_c;

    assign o_ready = (state_q == ST_RUN);
    assign accept  = i_valid & o_ready;

    // ------------------------------------------------------------------
    // Result registers: pulse for one cycle, data held until next accept
    // ------------------------------------------------------------------
    logic            res_valid_q;
    logic            jump_en_q;
    logic [XLEN-1:0] jump_addr_q;
    logic [XLEN-1:0] link_addr_q;
    logic            misalign_q;
    logic [XLEN-1:0] flush_addr_q;

    // Capture the resolved outcome of every accepted request.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            res_valid_q  <= 1'b0;
            jump_en_q    <= 1'b0;
            jump_addr_q  <= '0;
            link_addr_q  <= '0;
            misalign_q   <= 1'b0;
            flush_addr_q <= '0;
        end else begin
            res_valid_q <= accept;
            if (accept) begin
                jump_en_q    <= taken_c;
                jump_addr_q  <= target_c;
                link_addr_q  <= link_c;
                misalign_q   <= misalign_c;
                flush_addr_q <= redirect_c;
            end
        end
    end

    assign o_res_valid  = res_valid_q;
    assign o_jump_en    = jump_en_q;
    assign o_jump_addr  = jump_addr_q;
    assign o_link_addr  = link_addr_q;
    assign o_misalign   = misalign_q;
    // No request is accepted while flushing, so the redirect PC stays put.
    assign o_flush_addr = flush_addr_q;

    // ------------------------------------------------------------------
    // Redirect FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: enter FLUSH on a clean mispredict, leave on the IFU ack.
    // NOTE: state_d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (accept && mispredict_c && !misalign_c) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (i_flush_ack) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign o_flush_req = (state_q == ST_FLUSH);

    // ------------------------------------------------------------------
    // Branch history table
    // ------------------------------------------------------------------
`ifdef EXU_BJP_BHT_EN
    logic [1:0]       bht_q [BHT_DEPTH];
    logic             upd_valid_q;
    logic             upd_taken_q;
    logic [IDX_W-1:0] upd_idx_q;
    logic             lkp_unused;

    // Schedule a training update for the resolution cycle of a conditional
    // branch; misaligned taken branches are left to the trap path.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            upd_valid_q <= 1'b0;
            upd_taken_q <= 1'b0;
            upd_idx_q   <= '0;
        end else begin
            upd_valid_q <= accept & is_cond & ~misalign_c;
            if (accept) begin
                upd_taken_q <= taken_c;
                upd_idx_q   <= i_pc[IDX_W+1:2];
            end
        end
    end

    // Saturating counter update at the end of the resolution cycle.
    // NOTE: the counters are reset explicitly because fetch consumes them
    // right after reset and a weakly-not-taken start state is required.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (upd_valid_q) begin
            if (upd_taken_q) begin
                if (bht_q[upd_idx_q] != 2'b11) begin
                    bht_q[upd_idx_q] <= bht_q[upd_idx_q] + 2'b01;
                end
            end else begin
                if (bht_q[upd_idx_q] != 2'b00) begin
                    bht_q[upd_idx_q] <= bht_q[upd_idx_q] - 2'b01;
                end
            end
        end
    end

    // Lookup reads the registered table, so a same-cycle update is not visible.
    assign o_lkp_taken = bht_q[i_lkp_pc[IDX_W+1:2]][1];
    assign lkp_unused  = ^{i_lkp_pc[XLEN-1:IDX_W+2], i_lkp_pc[1:0]};
`else
    logic lkp_unused;

    assign o_lkp_taken = 1'b0;
    assign lkp_unused  = ^i_lkp_pc;
`endif

endmodule

// File: tb/tb_exu_bjp_unit.sv
// tb_exu_bjp_unit: directed and randomized self-checking bench for
// exu_bjp_unit. A behavioural model resolves each request from the branch
// rules and tracks flush state and (when EXU_BJP_BHT_EN is defined) the
// counter table as plain integers.
module tb_exu_bjp_unit;

    localparam int XLEN      = 32;
    localparam int BHT_DEPTH = 16;

    localparam logic [7:0] R_JAL  = 8'b1000_0000;
    localparam logic [7:0] R_JALR = 8'b0100_0000;
    localparam logic [7:0] R_BEQ  = 8'b0010_0000;
    localparam logic [7:0] R_BNE  = 8'b0001_0000;
    localparam logic [7:0] R_BLT  = 8'b0000_1000;
    localparam logic [7:0] R_BGE  = 8'b0000_0100;
    localparam logic [7:0] R_BLTU = 8'b0000_0010;
    localparam logic [7:0] R_BGEU = 8'b0000_0001;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_valid;
    logic            o_ready;
    logic [7:0]      i_jump_req;
    logic [2:0]      i_cmp_res;
    logic [XLEN-1:0] i_rs1, i_imm, i_pc;
    logic            i_pred_taken;
    logic [XLEN-1:0] i_pred_addr;
    logic            o_res_valid, o_jump_en, o_misalign, o_flush_req;
    logic [XLEN-1:0] o_jump_addr, o_link_addr, o_flush_addr;
    logic            i_flush_ack;
    logic [XLEN-1:0] i_lkp_pc;
    logic            o_lkp_taken;

    exu_bjp_unit #(.XLEN(XLEN), .BHT_DEPTH(BHT_DEPTH)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_jump_req   (i_jump_req),
        .i_cmp_res    (i_cmp_res),
        .i_rs1        (i_rs1),
        .i_imm        (i_imm),
        .i_pc         (i_pc),
        .i_pred_taken (i_pred_taken),
        .i_pred_addr  (i_pred_addr),
        .o_res_valid  (o_res_valid),
        .o_jump_en    (o_jump_en),
        .o_jump_addr  (o_jump_addr),
        .o_link_addr  (o_link_addr),
        .o_misalign   (o_misalign),
        .o_flush_req  (o_flush_req),
        .o_flush_addr (o_flush_addr),
        .i_flush_ack  (i_flush_ack),
        .i_lkp_pc     (i_lkp_pc),
        .o_lkp_taken  (o_lkp_taken)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    bit              m_flush;
    bit              m_res_valid, m_jump_en, m_mis;
    logic [XLEN-1:0] m_jump_addr, m_link, m_flush_addr;
    int              m_bht [BHT_DEPTH];
    bit              p_valid, p_taken;
    int              p_idx;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void resolve(input logic [7:0] req, input logic [2:0] cmp,
                                    input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] imm,
                                    input logic [XLEN-1:0] pc, input bit pt,
                                    input logic [XLEN-1:0] pa,
                                    output bit tk, output logic [XLEN-1:0] tgt,
                                    output bit mis, output bit mp);
        bit slt, sltu, eq;
        slt  = cmp[2];
        sltu = cmp[1];
        eq   = cmp[0];
        case (req)
            R_JAL, R_JALR: tk = 1'b1;
            R_BEQ:  tk = eq;
            R_BNE:  tk = !eq;
            R_BLT:  tk = slt;
            R_BGE:  tk = !slt;
            R_BLTU: tk = sltu;
            R_BGEU: tk = !sltu;
            default: tk = 1'b0;
        endcase
        if (req == R_JALR) tgt = (rs1 + imm) & ~32'd1;
        else               tgt = pc + imm;
        mis = tk && tgt[1];
        mp  = (req != 8'd0) && ((tk != pt) || (tk && (tgt != pa)));
    endfunction

    function automatic bit is_cond_req(input logic [7:0] req);
        return (req == R_BEQ) || (req == R_BNE) || (req == R_BLT) ||
               (req == R_BGE) || (req == R_BLTU) || (req == R_BGEU);
    endfunction

    function automatic bit exp_lkp(input logic [XLEN-1:0] pc);
`ifdef EXU_BJP_BHT_EN
        return m_bht[pc[5:2]] >= 2;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_flush = 0; m_res_valid = 0; m_jump_en = 0; m_mis = 0;
        m_jump_addr = '0; m_link = '0; m_flush_addr = '0;
        p_valid = 0; p_taken = 0; p_idx = 0;
        for (int i = 0; i < BHT_DEPTH; i++) m_bht[i] = 1;
    endtask

    // Called at posedge+1 with inputs already driven; ends at next posedge+1.
    task automatic run_cycle();
        bit acc, tk, mis, mp;
        logic [XLEN-1:0] tgt;
        logic [7:0] req;
        logic [XLEN-1:0] pc;
        bit ack;
        #1;
        check("ready", o_ready, !m_flush);
        check("lkp", o_lkp_taken, exp_lkp(i_lkp_pc));
        acc = i_valid && !m_flush;
        req = i_jump_req;
        pc  = i_pc;
        ack = i_flush_ack;
        resolve(i_jump_req, i_cmp_res, i_rs1, i_imm, i_pc, i_pred_taken, i_pred_addr,
                tk, tgt, mis, mp);
        @(posedge i_clk);
        if (p_valid) begin
            if (p_taken) m_bht[p_idx] = (m_bht[p_idx] == 3) ? 3 : m_bht[p_idx] + 1;
            else         m_bht[p_idx] = (m_bht[p_idx] == 0) ? 0 : m_bht[p_idx] - 1;
        end
        p_valid = acc && is_cond_req(req) && !mis;
        p_taken = tk;
        p_idx   = int'(pc[5:2]);
        m_res_valid = acc;
        if (acc) begin
            m_jump_en    = tk;
            m_jump_addr  = tgt;
            m_link       = pc + 32'd4;
            m_mis        = mis;
            m_flush_addr = tk ? tgt : pc + 32'd4;
            if (mp && !mis) m_flush = 1;
        end else if (m_flush && ack) begin
            m_flush = 0;
        end
        #1;
        check("res_valid", o_res_valid, m_res_valid);
        check("jump_en", o_jump_en, m_jump_en);
        check("jump_addr", o_jump_addr, m_jump_addr);
        check("link_addr", o_link_addr, m_link);
        check("misalign", o_misalign, m_mis);
        check("flush_req", o_flush_req, m_flush);
        check("flush_addr", o_flush_addr, m_flush_addr);
    endtask

    task automatic set_req(input logic [7:0] req, input logic [2:0] cmp,
                           input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] imm,
                           input logic [XLEN-1:0] pc, input bit pt,
                           input logic [XLEN-1:0] pa);
        i_valid = 1; i_jump_req = req; i_cmp_res = cmp; i_rs1 = rs1;
        i_imm = imm; i_pc = pc; i_pred_taken = pt; i_pred_addr = pa;
        i_flush_ack = 0;
    endtask

    task automatic idle();
        i_valid = 0; i_flush_ack = 0; i_jump_req = 8'd0;
    endtask

    task automatic random_req();
        bit tk, mis, mp;
        logic [XLEN-1:0] tgt;
        logic [7:0] req;
        int sel;
        sel = $urandom_range(0, 8);
        req = (sel == 8) ? 8'd0 : (8'd1 << sel);
        i_valid      = ($urandom_range(0, 9) < 8);
        i_jump_req   = req;
        i_cmp_res    = 3'($urandom);
        i_rs1        = $urandom;
        i_imm        = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFE)
                                                   : (32'($urandom_range(0, 255)) << 1);
        i_pc         = 32'($urandom_range(0, 63)) << 2;
        i_pred_taken = $urandom_range(0, 1);
        resolve(i_jump_req, i_cmp_res, i_rs1, i_imm, i_pc, 1'b0, '0, tk, tgt, mis, mp);
        i_pred_addr  = ($urandom_range(0, 3) != 0) ? tgt : $urandom;
        i_flush_ack  = ($urandom_range(0, 2) == 0);
        i_lkp_pc     = 32'($urandom_range(0, 63)) << 2;
    endtask

    initial begin
        model_reset();
        i_rst_n = 0;
        idle();
        i_cmp_res = 0; i_rs1 = 0; i_imm = 0; i_pc = 0;
        i_pred_taken = 0; i_pred_addr = 0; i_lkp_pc = 0;
        #2;
        check("rst_res_valid", o_res_valid, 0);
        check("rst_jump_en", o_jump_en, 0);
        check("rst_jump_addr", o_jump_addr, 0);
        check("rst_link_addr", o_link_addr, 0);
        check("rst_misalign", o_misalign, 0);
        check("rst_flush_req", o_flush_req, 0);
        check("rst_flush_addr", o_flush_addr, 0);
        check("rst_ready", o_ready, 1);
        check("rst_lkp", o_lkp_taken, 0);
        #10 i_rst_n = 1;
        @(posedge i_clk); #1;

        // beq taken, correctly predicted
        set_req(R_BEQ, 3'b001, 0, 32'h20, 32'h100, 1, 32'h120);
        run_cycle();
        check("tp1_jump_en", o_jump_en, 1);
        check("tp1_jump_addr", o_jump_addr, 32'h120);
        check("tp1_flush", o_flush_req, 0);

        // bne not taken but predicted taken -> flush to pc+4, held 3 cycles
        set_req(R_BNE, 3'b001, 0, 32'h40, 32'h200, 1, 32'h240);
        run_cycle();
        check("tp2_jump_en", o_jump_en, 0);
        check("tp2_flush_req", o_flush_req, 1);
        check("tp2_flush_addr", o_flush_addr, 32'h204);
        set_req(R_JAL, 3'b000, 0, 32'h8, 32'h500, 0, 32'h0);
        for (int i = 0; i < 3; i++) run_cycle();
        check("tp2_held_req", o_flush_req, 1);
        check("tp2_held_addr", o_flush_addr, 32'h204);
        check("tp2_held_ready", o_ready, 0);
        idle();
        i_flush_ack = 1;
        run_cycle();
        check("tp2_ack_req", o_flush_req, 0);
        check("tp2_ack_ready", o_ready, 1);

        // jalr: bit 0 cleared, mispredicted target
        set_req(R_JALR, 3'b000, 32'h1001, 32'h4, 32'h300, 1, 32'h1000);
        run_cycle();
        check("tp3_jump_addr", o_jump_addr, 32'h1004);
        check("tp3_link_addr", o_link_addr, 32'h304);
        check("tp3_flush_addr", o_flush_addr, 32'h1004);
        check("tp3_flush_req", o_flush_req, 1);
        idle();
        i_flush_ack = 1;
        run_cycle();

        // jal to misaligned target: no flush
        set_req(R_JAL, 3'b000, 0, 32'h6, 32'h0, 0, 32'h0);
        run_cycle();
        check("tp4_misalign", o_misalign, 1);
        check("tp4_flush", o_flush_req, 0);

        // BHT training at pc 0x40: three taken blt, then four not-taken bge
        i_lkp_pc = 32'h40;
        for (int i = 0; i < 3; i++) begin
            set_req(R_BLT, 3'b100, 0, 32'h10, 32'h40, 1, 32'h50);
            run_cycle();
        end
        idle();
        run_cycle();
        run_cycle();
`ifdef EXU_BJP_BHT_EN
        check("tp5_sat_taken", o_lkp_taken, 1);
`endif
        for (int i = 0; i < 4; i++) begin
            set_req(R_BGE, 3'b100, 0, 32'h10, 32'h40, 0, 32'h0);
            run_cycle();
        end
        idle();
        run_cycle();
        run_cycle();
        check("tp5_back_to_nt", o_lkp_taken, 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            random_req();
            run_cycle();
        end

        // Back-to-back bge, then reset in the middle of a flush
        idle();
        i_flush_ack = 1;
        for (int i = 0; i < 3; i++) run_cycle();
        for (int i = 0; i < 4; i++) begin
            set_req(R_BGE, 3'b000, 0, 32'h8, 32'h80 + 32'(i * 4), 1, 32'h88 + 32'(i * 4));
            run_cycle();
        end
        set_req(R_BGE, 3'b100, 0, 32'h8, 32'h90, 1, 32'h98);
        run_cycle();
        check("tp6_flush_up", o_flush_req, 1);
        #2 i_rst_n = 0;
        #1;
        check("tp6_rst_flush_req", o_flush_req, 0);
        check("tp6_rst_res_valid", o_res_valid, 0);
        check("tp6_rst_jump_en", o_jump_en, 0);
        check("tp6_rst_jump_addr", o_jump_addr, 0);
        check("tp6_rst_flush_addr", o_flush_addr, 0);
        check("tp6_rst_lkp", o_lkp_taken, 0);
        idle();
        model_reset();
        #1 i_rst_n = 1;
        @(posedge i_clk); #1;
        check("tp6_ready_after", o_ready, 1);
        for (int n = 0; n < 50; n++) begin
            random_req();
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
